// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared types and constants for the AES trace sequencer
package aes_seq_pkg;

  localparam int AES_BLK_W        = 128;
  localparam int DEF_GAP_CYCLES   = 255;
  localparam int DEF_BUSY_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_RISE = 3'd3,
    ST_WAIT_FALL = 3'd4,
    ST_CAPTURE   = 3'd5,
    ST_ERROR     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down-counter that stops at zero
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         ICE_CLK,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i && count_q != '0)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/aes_trace_sequencer.sv
// rtl/aes_trace_sequencer.sv - drives aes_core through repeated capture traces
module aes_trace_sequencer
  import aes_seq_pkg::*;
#(
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int CNT_W        = 16
) (
  input  logic                 ICE_CLK,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [CNT_W-1:0]     num_traces_i,
  input  logic [AES_BLK_W-1:0] pt_seed_i,
  output logic                 aes_load_o,
  output logic [AES_BLK_W-1:0] aes_data_o,
  input  logic                 aes_busy_i,
  input  logic [AES_BLK_W-1:0] aes_result_i,
  output logic                 trigger_o,
  output logic [AES_BLK_W-1:0] result_o,
  output logic                 result_valid_o,
  output logic [CNT_W-1:0]     trace_count_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

  seq_state_e state_q, state_d;

  logic [AES_BLK_W-1:0] pt_q, result_q;
  logic [CNT_W-1:0]     target_q, count_q, count_inc;
  logic                 done_q, error_q, stop_pending_q;
  logic                 gap_zero, to_zero, gap_load, start_go, finish;

  assign start_go  = (state_q == ST_IDLE || state_q == ST_ERROR) && start_i;
  assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
  assign finish    = stop_pending_q || stop_i ||
                     (target_q != '0 && count_inc == target_q);
  assign gap_load  = start_go || (state_q == ST_CAPTURE && !finish);

  // Loaded one short so the GAP state itself lasts exactly GAP_CYCLES cycles.
  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .ICE_CLK    (ICE_CLK),
    .resetn     (resetn),
    .load_i     (gap_load),
    .load_val_i (GAP_W'(GAP_CYCLES - 1)),
    .dec_i      (state_q == ST_GAP),
    .zero_o     (gap_zero)
  );

  seq_down_counter #(.W(TO_W)) u_to_cnt (
    .ICE_CLK    (ICE_CLK),
    .resetn     (resetn),
    .load_i     (state_q == ST_LOAD),
    .load_val_i (TO_W'(BUSY_TIMEOUT)),
    .dec_i      (state_q == ST_WAIT_RISE),
    .zero_o     (to_zero)
  );

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERROR: if (start_i) state_d = ST_GAP;
      ST_GAP: begin
        if (stop_i)                       state_d = ST_IDLE;
        else if (gap_zero && !aes_busy_i) state_d = ST_LOAD;
      end
      ST_LOAD:      state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (aes_busy_i)   state_d = ST_WAIT_FALL;
        else if (to_zero) state_d = ST_ERROR;
      end
      ST_WAIT_FALL: if (!aes_busy_i) state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = finish ? ST_IDLE : ST_GAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    aes_load_o     = 1'b0;
    trigger_o      = 1'b0;
    result_valid_o = 1'b0;
    running_o      = !(state_q == ST_IDLE || state_q == ST_ERROR);
    case (state_q)
      ST_LOAD: begin
        aes_load_o = !aes_busy_i;
        trigger_o  = 1'b1;
      end
      ST_WAIT_RISE, ST_WAIT_FALL: trigger_o = 1'b1;
      ST_CAPTURE: begin
        trigger_o      = 1'b1;
        result_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ICE_CLK) begin
    if (!resetn) begin
      pt_q           <= '0;
      result_q       <= '0;
      target_q       <= '0;
      count_q        <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      if (start_go) begin
        pt_q           <= pt_seed_i;
        target_q       <= num_traces_i;
        count_q        <= '0;
        done_q         <= 1'b0;
        error_q        <= 1'b0;
        stop_pending_q <= 1'b0;
      end
      if (state_q == ST_GAP && stop_i)
        done_q <= 1'b1;
      if (stop_i && state_q inside {ST_LOAD, ST_WAIT_RISE, ST_WAIT_FALL, ST_CAPTURE})
        stop_pending_q <= 1'b1;
      // Capture as busy falls so result_o is already valid during CAPTURE.
      if (state_q == ST_WAIT_FALL && !aes_busy_i)
        result_q <= aes_result_i;
      if (state_q == ST_WAIT_RISE && !aes_busy_i && to_zero)
        error_q <= 1'b1;
      if (state_q == ST_CAPTURE) begin
        count_q <= count_inc;
        pt_q    <= pt_q + AES_BLK_W'(1);
        if (finish) done_q <= 1'b1;
      end
    end
  end

  assign aes_data_o    = pt_q;
  assign result_o      = result_q;
  assign trace_count_o = count_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// tb/tb_aes_trace_sequencer.sv - directed self-checking bench for aes_trace_sequencer
module tb_aes_trace_sequencer;

  localparam logic [127:0] MASK  = {4{32'hA5A5_5A5A}};
  localparam logic [127:0] SEED1 = 128'h00112233445566778899aabbccddeeff;

  logic         ICE_CLK, resetn, start_i, stop_i;
  logic [15:0]  num_traces_i;
  logic [127:0] pt_seed_i;
  logic         aes_load_o, aes_busy_i;
  logic [127:0] aes_data_o, aes_result_i;
  logic         trigger_o, result_valid_o, running_o, done_o, error_o;
  logic [127:0] result_o;
  logic [15:0]  trace_count_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_left = 0;
  int busy_len = 11;
  logic never_busy = 1'b0;
  logic [127:0] core_q = '0;

  logic [127:0] load_data[$];
  int           load_cyc[$];
  logic         load_busy[$];
  logic [127:0] res_data[$];

  aes_trace_sequencer #(.GAP_CYCLES(4), .BUSY_TIMEOUT(15), .CNT_W(16)) dut (
    .ICE_CLK        (ICE_CLK),
    .resetn         (resetn),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .num_traces_i   (num_traces_i),
    .pt_seed_i      (pt_seed_i),
    .aes_load_o     (aes_load_o),
    .aes_data_o     (aes_data_o),
    .aes_busy_i     (aes_busy_i),
    .aes_result_i   (aes_result_i),
    .trigger_o      (trigger_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .trace_count_o  (trace_count_o),
    .running_o      (running_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  initial begin
    ICE_CLK = 1'b0;
    forever #5 ICE_CLK = ~ICE_CLK;
  end

  always @(posedge ICE_CLK) cyc <= cyc + 1;

  // Core model: busy for busy_len cycles after a load, result = data ^ MASK.
  always @(posedge ICE_CLK) begin
    if (aes_load_o && !never_busy) begin
      busy_left <= busy_len;
      core_q    <= aes_data_o ^ MASK;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign aes_busy_i   = (busy_left > 0);
  assign aes_result_i = core_q;

  always @(negedge ICE_CLK) begin
    if (aes_load_o) begin
      load_data.push_back(aes_data_o);
      load_cyc.push_back(cyc);
      load_busy.push_back(aes_busy_i);
    end
    if (result_valid_o) res_data.push_back(result_o);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    load_data.delete();
    load_cyc.delete();
    load_busy.delete();
    res_data.delete();
  endtask

  task automatic pulse_start(input logic [15:0] num, input logic [127:0] seed);
    @(posedge ICE_CLK); #1;
    start_i = 1'b1; num_traces_i = num; pt_seed_i = seed;
    @(posedge ICE_CLK); #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge ICE_CLK); #1;
    stop_i = 1'b1;
    @(posedge ICE_CLK); #1;
    stop_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (running_o && n < budget) begin
      @(negedge ICE_CLK);
      n++;
    end
    check(tag, running_o, 1'b0);
  endtask

  task automatic wait_loads(input string tag, input int cnt, input int budget);
    int n = 0;
    while (load_data.size() < cnt && n < budget) begin
      @(negedge ICE_CLK);
      n++;
    end
    check(tag, load_data.size() >= cnt, 1'b1);
  endtask

  task automatic check_loads_idle_core(input string tag);
    foreach (load_busy[i]) check(tag, load_busy[i], 1'b0);
  endtask

  initial begin
    int t0, diff;
    resetn = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    num_traces_i = '0; pt_seed_i = '0;
    repeat (2) @(posedge ICE_CLK);
    #1 resetn = 1'b1;
    @(negedge ICE_CLK);
    check("rst_running", running_o, 1'b0);
    check("rst_data", aes_data_o, '0);
    check("rst_count", trace_count_o, '0);
    check("rst_trigger", trigger_o, 1'b0);
    check("rst_done_err", {done_o, error_o, aes_load_o, result_valid_o}, '0);

    // Basic three-trace run
    clear_log();
    pulse_start(16'd3, SEED1);
    wait_idle("basic_end", 200);
    check("basic_nloads", load_data.size(), 3);
    check("basic_pt0", load_data[0], SEED1);
    check("basic_pt1", load_data[1], 128'h00112233445566778899aabbccddef00);
    check("basic_pt2", load_data[2], 128'h00112233445566778899aabbccddef01);
    check("basic_space01", load_cyc[1] - load_cyc[0], 18);
    check("basic_space12", load_cyc[2] - load_cyc[1], 18);
    check("basic_nres", res_data.size(), 3);
    check("basic_res0", res_data[0], SEED1 ^ MASK);
    check("basic_res2", res_data[2], 128'h00112233445566778899aabbccddef01 ^ MASK);
    check("basic_count", trace_count_o, 16'd3);
    check("basic_done", done_o, 1'b1);
    check_loads_idle_core("basic_load_busy");

    // Plaintext wrap
    clear_log();
    pulse_start(16'd2, {128{1'b1}});
    wait_idle("wrap_end", 200);
    check("wrap_pt0", load_data[0], {128{1'b1}});
    check("wrap_pt1", load_data[1], 128'h0);
    check("wrap_count", trace_count_o, 16'd2);

    // Stop during the second encryption, unlimited mode
    clear_log();
    pulse_start(16'd0, 128'h5);
    wait_loads("stop_second_load", 2, 200);
    repeat (2) @(posedge ICE_CLK);
    pulse_stop();
    wait_idle("stop_end", 200);
    repeat (40) @(negedge ICE_CLK);
    check("stop_nloads", load_data.size(), 2);
    check("stop_nres", res_data.size(), 2);
    check("stop_res1", res_data[1], 128'h6 ^ MASK);
    check("stop_count", trace_count_o, 16'd2);
    check("stop_done", done_o, 1'b1);

    // Stop during GAP: no load at all
    clear_log();
    pulse_start(16'd0, 128'h9);
    pulse_stop();
    @(negedge ICE_CLK);
    check("gapstop_running", running_o, 1'b0);
    check("gapstop_done", done_o, 1'b1);
    check("gapstop_nloads", load_data.size(), 0);

    // Busy timeout
    clear_log();
    never_busy = 1'b1;
    pulse_start(16'd1, 128'h77);
    wait_loads("to_load", 1, 50);
    t0 = load_cyc[0];
    begin
      int n = 0;
      while (!error_o && n < 40) begin
        @(negedge ICE_CLK);
        n++;
      end
    end
    diff = cyc - t0;
    check("to_error", error_o, 1'b1);
    check("to_latency_le17", diff <= 17, 1'b1);
    check("to_trigger", trigger_o, 1'b0);
    check("to_running", running_o, 1'b0);
    never_busy = 1'b0;
    pulse_start(16'd1, 128'h78);
    @(negedge ICE_CLK);
    check("to_restart_clr", error_o, 1'b0);
    wait_idle("to_restart_end", 200);
    check("to_restart_done", {done_o, trace_count_o}, {1'b1, 16'd1});

    // Reset during WAIT_FALL with core still busy 5 more cycles
    clear_log();
    pulse_start(16'd1, 128'hAB);
    wait_loads("rmid_load", 1, 50);
    t0 = load_cyc[0];
    repeat (6) @(posedge ICE_CLK);
    #1 resetn = 1'b0;
    @(posedge ICE_CLK); #1;
    resetn = 1'b1;
    start_i = 1'b1; num_traces_i = 16'd1; pt_seed_i = 128'hCD;
    @(negedge ICE_CLK);
    check("rmid_outs", {aes_load_o, trigger_o, result_valid_o, running_o, done_o, error_o}, '0);
    check("rmid_data", aes_data_o, '0);
    check("rmid_result", result_o, '0);
    check("rmid_count", trace_count_o, '0);
    @(posedge ICE_CLK); #1;
    start_i = 1'b0;
    wait_loads("rmid_load2", 2, 60);
    check("rmid_delay", load_cyc[1] - t0, 13);
    check("rmid_pt", load_data[1], 128'hCD);
    wait_idle("rmid_end", 200);
    check_loads_idle_core("rmid_load_busy");

    // Start+stop together in IDLE, then start while running
    clear_log();
    @(posedge ICE_CLK); #1;
    start_i = 1'b1; stop_i = 1'b1; num_traces_i = 16'd2; pt_seed_i = 128'h100;
    @(posedge ICE_CLK); #1;
    start_i = 1'b0; stop_i = 1'b0;
    @(negedge ICE_CLK);
    check("ss_running", running_o, 1'b1);
    wait_loads("ss_load", 1, 50);
    pulse_start(16'd7, 128'h999);
    wait_idle("ss_end", 200);
    check("ss_nloads", load_data.size(), 2);
    check("ss_pt1", load_data[1], 128'h101);
    check("ss_count", trace_count_o, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
